// File: rtl/wishbone_slave_mem.sv
// rtl/wishbone_slave_mem.sv - Wishbone word-memory slave with byte lanes, wait states and range checking
module wishbone_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter int          TAGSIZE     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [TAGSIZE-1:0] wb_tgc_i,
  input  logic               hold_i,
  output logic [31:0]        wb_dat_o,
  output logic [TAGSIZE-1:0] wb_tgd_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {R_ACK, R_ERR, R_RTY} resp_t;

  state_t               state_q, state_d;
  resp_t                resp_q, resp_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          dat_q, dat_d;
  logic [TAGSIZE-1:0]   tgc_q, tgc_d;

  logic [31:0] mem [DEPTH];

  logic request;
  logic addr_ok;
  logic in_resp;
  logic mem_wr;

  assign request = wb_cyc_i & wb_stb_i;
  // Base is DEPTH*4 aligned, so the window test reduces to matching the upper address bits.
  assign addr_ok = (wb_adr_i[1:0] == 2'b00) &&
                   (wb_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    tgc_d   = tgc_q;
    case (state_q)
      S_IDLE: begin
        if (request) begin
          idx_d = wb_adr_i[AW+1:2];
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          tgc_d = wb_tgc_i;
          if (hold_i) begin
            resp_d  = R_RTY;
            state_d = S_RESP;
          end else if (!addr_ok) begin
            resp_d  = R_ERR;
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            resp_d  = R_ACK;
            state_d = S_RESP;
          end else begin
            resp_d  = R_ACK;
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A master dropping cyc abandons the access; nothing is written or terminated.
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          resp_d  = R_ACK;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      resp_q  <= R_ACK;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      tgc_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      tgc_q   <= tgc_d;
    end
  end

  assign in_resp = (state_q == S_RESP);
  assign mem_wr  = in_resp && (resp_q == R_ACK) && we_q;

  // Storage is deliberately left unreset so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_q[n]) begin
          mem[idx_q][8*n +: 8] <= dat_q[8*n +: 8];
        end
      end
    end
  end

  assign wb_ack_o = in_resp && (resp_q == R_ACK);
  assign wb_err_o = in_resp && (resp_q == R_ERR);
  assign wb_rty_o = in_resp && (resp_q == R_RTY);
  assign wb_tgd_o = in_resp ? tgc_q : '0;
  assign wb_dat_o = (wb_ack_o && !we_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// tb/tb_wishbone_slave_mem.sv - scoreboard bench for wishbone_slave_mem (zero-wait and three-wait instances)
module tb_wishbone_slave_mem;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;
  localparam logic [2:0]  K_ACK = 3'b100;
  localparam logic [2:0]  K_ERR = 3'b010;
  localparam logic [2:0]  K_RTY = 3'b001;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
    logic [1:0]  tag;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic        hold;
    logic [31:0] off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  kind;
    logic [31:0] edat;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we = 1'b0, hold = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic [1:0]  tgc = 2'd0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;

  logic [31:0] o0_dat, o3_dat;
  logic [1:0]  o0_tgd, o3_tgd;
  logic        o0_ack, o0_err, o0_rty, o3_ack, o3_err, o3_rty;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  resp_t exp_q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  wishbone_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0), .TAGSIZE(2)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_tgc_i(tgc), .hold_i(hold),
    .wb_dat_o(o0_dat), .wb_tgd_o(o0_tgd), .wb_ack_o(o0_ack), .wb_err_o(o0_err), .wb_rty_o(o0_rty)
  );

  wishbone_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3), .TAGSIZE(2)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_tgc_i(tgc), .hold_i(hold),
    .wb_dat_o(o3_dat), .wb_tgd_o(o3_tgd), .wb_ack_o(o3_ack), .wb_err_o(o3_err), .wb_rty_o(o3_rty)
  );

  function automatic resp_t snap(input bit d3);
    if (d3) return {o3_ack, o3_err, o3_rty, o3_dat, o3_tgd};
    return {o0_ack, o0_err, o0_rty, o0_dat, o0_tgd};
  endfunction

  // Single access: returns the observed termination and its latency in cycles (-1 on timeout).
  task automatic access(input bit d3, input logic w, input logic h, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [1:0] t,
                        output resp_t obs, output int lat);
    int start;
    bit got;
    resp_t cur;
    @(posedge clk_i); #1;
    we = w; hold = h; adr = a; dat = d; sel = s; tgc = t;
    if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end else begin cyc0 = 1'b1; stb0 = 1'b1; end
    start = cyc_cnt;
    got = 1'b0;
    obs = '0;
    lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      cur = snap(d3);
      if (cur.kind != 3'b000) begin
        got = 1'b1;
        obs = cur;
        lat = cyc_cnt - start;
      end
    end
    @(posedge clk_i); #1;
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset;
    resp_t r0, r3;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    r0 = snap(1'b0);
    r3 = snap(1'b1);
    checks++;
    if (r0 !== '0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", r0); end
    checks++;
    if (r3 !== '0) begin failures++; $display("FAIL reset_dut3 got=%h exp=0", r3); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_single_word;
    resp_t obs, exp;
    int lat;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({K_ACK, (i == 0) ? 32'h0 : 32'hDEAD_BEEF, 2'(i + 1)});
      access(1'b0, (i == 0), 1'b0, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 2'(i + 1), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL single_word[%0d] got=%h exp=%h", i, obs, exp); end
      checks++;
      if (lat != 1) begin failures++; $display("FAIL single_word_lat[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_byte_lanes;
    txn_t tbl [5] = '{
      '{1'b1, 1'b0, 32'h0, 32'h1122_3344, 4'hF, K_ACK, 32'h0},
      '{1'b1, 1'b0, 32'h0, 32'hAABB_CCDD, 4'h5, K_ACK, 32'h0},
      '{1'b0, 1'b0, 32'h0, 32'h0,         4'h0, K_ACK, 32'h11BB_33DD},
      '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 4'h0, K_ACK, 32'h0},
      '{1'b0, 1'b0, 32'h0, 32'h0,         4'hF, K_ACK, 32'h11BB_33DD}
    };
    resp_t obs, exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({tbl[i].kind, tbl[i].edat, 2'(i)});
      access(1'b0, tbl[i].we, tbl[i].hold, BASE + tbl[i].off, tbl[i].dat, tbl[i].sel, 2'(i), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL byte_lanes[%0d] got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_errors;
    txn_t tbl [7] = '{
      '{1'b1, 1'b0, 32'h2,          32'hFFFF_FFFF, 4'hF, K_ERR, 32'h0},
      '{1'b1, 1'b0, 32'h400,        32'hFFFF_FFFF, 4'hF, K_ERR, 32'h0},
      '{1'b0, 1'b0, 32'hFFFF_FFFC,  32'h0,         4'hF, K_ERR, 32'h0},
      '{1'b0, 1'b0, 32'h1,          32'h0,         4'hF, K_ERR, 32'h0},
      '{1'b1, 1'b0, 32'h3FC,        32'h0BAD_F00D, 4'hF, K_ACK, 32'h0},
      '{1'b0, 1'b0, 32'h3FC,        32'h0,         4'hF, K_ACK, 32'h0BAD_F00D},
      '{1'b0, 1'b0, 32'h0,          32'h0,         4'hF, K_ACK, 32'h11BB_33DD}
    };
    resp_t obs, exp;
    int lat;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({tbl[i].kind, tbl[i].edat, 2'(i)});
      access(1'b0, tbl[i].we, tbl[i].hold, BASE + tbl[i].off, tbl[i].dat, tbl[i].sel, 2'(i), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL errors[%0d] got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_hold;
    txn_t tbl [6] = '{
      '{1'b1, 1'b0, 32'hC, 32'h0102_0304, 4'hF, K_ACK, 32'h0},
      '{1'b1, 1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, K_RTY, 32'h0},
      '{1'b0, 1'b1, 32'hC, 32'h0,         4'hF, K_RTY, 32'h0},
      '{1'b0, 1'b0, 32'hC, 32'h0,         4'hF, K_ACK, 32'h0102_0304},
      '{1'b1, 1'b0, 32'hC, 32'hCAFE_F00D, 4'hF, K_ACK, 32'h0},
      '{1'b0, 1'b0, 32'hC, 32'h0,         4'hF, K_ACK, 32'hCAFE_F00D}
    };
    resp_t obs, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({tbl[i].kind, tbl[i].edat, 2'(i)});
      access(1'b0, tbl[i].we, tbl[i].hold, BASE + tbl[i].off, tbl[i].dat, tbl[i].sel, 2'(i), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL hold[%0d] got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_wait_states;
    resp_t obs, exp;
    int lat;
    logic [2:0] seen;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({K_ACK, (i == 0) ? 32'h0 : 32'h5555_AAAA, 2'(i + 2)});
      access(1'b1, (i == 0), 1'b0, BASE + 32'h10, 32'h5555_AAAA, 4'hF, 2'(i + 2), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL wait_resp[%0d] got=%h exp=%h", i, obs, exp); end
      checks++;
      if (lat != 4) begin failures++; $display("FAIL wait_lat[%0d] got=%0d exp=4", i, lat); end
    end
    // Aborted write: cyc drops two cycles after the request is seen.
    @(posedge clk_i); #1;
    we = 1'b1; adr = BASE + 32'h10; dat = 32'h1234_5678; sel = 4'hF; tgc = 2'd1;
    cyc3 = 1'b1; stb3 = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    cyc3 = 1'b0; stb3 = 1'b0;
    seen = 3'b000;
    repeat (8) begin
      @(negedge clk_i);
      seen = seen | {o3_ack, o3_err, o3_rty};
    end
    checks++;
    if (seen !== 3'b000) begin failures++; $display("FAIL wait_abort_term got=%b exp=000", seen); end
    exp_q.push_back({K_ACK, 32'h5555_AAAA, 2'd0});
    access(1'b1, 1'b0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 2'd0, obs, lat);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL wait_abort_nowrite got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back;
    resp_t obs, exp;
    int lat, prev, now;
    bit got;
    for (int k = 0; k < 4; k++) exp_q.push_back({K_ACK, 32'h0, 2'(k)});
    @(posedge clk_i); #1;
    we = 1'b1; hold = 1'b0; sel = 4'hF; adr = BASE + 32'h40; dat = 32'hB000_0000; tgc = 2'd0;
    cyc0 = 1'b1; stb0 = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      now = 0;
      obs = '0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk_i);
        if ({o0_ack, o0_err, o0_rty} != 3'b000) begin
          got = 1'b1;
          obs = snap(1'b0);
          now = cyc_cnt;
        end
      end
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL burst[%0d] got=%h exp=%h", k, obs, exp); end
      if (k > 0) begin
        checks++;
        if (now - prev != 2) begin failures++; $display("FAIL burst_gap[%0d] got=%0d exp=2", k, now - prev); end
      end
      prev = now;
      @(posedge clk_i); #1;
      if (k < 3) begin
        adr = adr + 32'h4;
        dat = 32'hB000_0000 + 32'(k + 1);
        tgc = 2'(k + 1);
      end else begin
        cyc0 = 1'b0; stb0 = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({K_ACK, 32'hB000_0000 + 32'(k), 2'(3 - k)});
      access(1'b0, 1'b0, 1'b0, BASE + 32'h40 + 32'(4 * k), 32'h0, 4'h0, 2'(3 - k), obs, lat);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL burst_read[%0d] got=%h exp=%h", k, obs, exp); end
    end
  endtask

  task automatic test_reset_mid_wait;
    resp_t obs, exp;
    int lat;
    logic [2:0] seen;
    exp_q.push_back({K_ACK, 32'h0, 2'd1});
    access(1'b1, 1'b1, 1'b0, BASE + 32'h20, 32'h7777_0077, 4'hF, 2'd1, obs, lat);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_prewrite got=%h exp=%h", obs, exp); end
    @(posedge clk_i); #1;
    we = 1'b1; adr = BASE + 32'h20; dat = 32'h9999_9999; sel = 4'hF; tgc = 2'd3;
    cyc3 = 1'b1; stb3 = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    obs = snap(1'b1);
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rst_mid_wait_outputs got=%h exp=0", obs); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    seen = 3'b000;
    repeat (6) begin
      @(negedge clk_i);
      seen = seen | {o3_ack, o3_err, o3_rty};
    end
    checks++;
    if (seen !== 3'b000) begin failures++; $display("FAIL rst_mid_wait_term got=%b exp=000", seen); end
    exp_q.push_back({K_ACK, 32'h7777_0077, 2'd2});
    access(1'b1, 1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 2'd2, obs, lat);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL rst_discard got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_byte_lanes();
    test_errors();
    test_hold();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
